// File: rtl/fetch_pkg.sv
// Shared defaults and phase encoding for the fetch sequencer.
// The call stack is built only when FETCH_CALL_STACK_EN is defined.
package fetch_pkg;

    localparam int PC_W_DEF        = 12;
    localparam int INSTR_W_DEF     = 4;
    localparam int OPRND_W_DEF     = 4;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic {
        PH_FETCH = 1'b0,
        PH_EXEC  = 1'b1
    } phase_e;

endpackage

// File: rtl/fetch_sequencer_call_stack.sv
// LIFO of return addresses for the fetch sequencer.
// Push is ignored when full, pop is ignored when empty.
module call_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 12
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    // Top-of-stack index wraps to DEPTH-1 when a power-of-two stack is full.
    assign wr_idx = level_q[IDX_W-1:0];
    assign rd_idx = wr_idx - IDX_W'(1);

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_idx];

    always_comb begin
        mem_d   = mem_q;
        level_d = level_q;
        if (push && !full) begin
            mem_d[wr_idx] = din;
            level_d       = level_q + LVL_W'(1);
        end else if (pop && !empty) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Two-phase fetch/execute program sequencer with optional call stack.
// Define FETCH_CALL_STACK_EN to enable call/ret and stack_err/stack_level.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int INSTR_W     = INSTR_W_DEF,
    parameter int OPRND_W     = OPRND_W_DEF,
    parameter int STACK_DEPTH = STACK_DEPTH_DEF
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             enable,
    input  logic [INSTR_W+OPRND_W-1:0]       program_byte,
    input  logic                             load_pc,
    input  logic                             call,
    input  logic                             ret,
    input  logic [PC_W-1:0]                  load_addr,
    output logic [PC_W-1:0]                  PC,
    output logic                             phase,
    output logic [INSTR_W-1:0]               instr,
    output logic [OPRND_W-1:0]               oprnd,
    output logic                             stack_err,
    output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level
);

    localparam int LVL_W = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_d;
    phase_e             phase_q;
    phase_e             phase_d;
    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] instr_d;
    logic [OPRND_W-1:0] oprnd_q;
    logic [OPRND_W-1:0] oprnd_d;

`ifdef FETCH_CALL_STACK_EN
    logic               err_q;
    logic               err_d;
    logic               stk_push;
    logic               stk_pop;
    logic               stk_full;
    logic               stk_empty;
    logic [PC_W-1:0]    stk_dout;
    logic [LVL_W-1:0]   stk_level;

    // Reset wins inside the stack, so a coincident push/pop is discarded.
    call_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_call_stack (
        .clock (clock),
        .reset (reset),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_q),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty),
        .level (stk_level)
    );

    assign stack_err   = err_q;
    assign stack_level = stk_level;
`else
    logic unused_stack_req;

    assign unused_stack_req = call ^ ret;
    assign stack_err        = 1'b0;
    assign stack_level      = '0;
`endif

    always_comb begin
        pc_d    = pc_q;
        phase_d = phase_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
`ifdef FETCH_CALL_STACK_EN
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
`endif
        if (enable) begin
            if (phase_q == PH_FETCH) begin
                instr_d = program_byte[INSTR_W+OPRND_W-1 -: INSTR_W];
                oprnd_d = program_byte[OPRND_W-1:0];
                pc_d    = pc_q + PC_W'(1);
                phase_d = PH_EXEC;
            end else begin
                phase_d = PH_FETCH;
`ifdef FETCH_CALL_STACK_EN
                if (ret) begin
                    if (!stk_empty) begin
                        pc_d    = stk_dout;
                        stk_pop = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (call) begin
                    if (!stk_full) begin
                        pc_d     = load_addr;
                        stk_push = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (load_pc) begin
                    pc_d = load_addr;
                end
`else
                if (load_pc) begin
                    pc_d = load_addr;
                end
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            phase_q <= PH_FETCH;
            instr_q <= '0;
            oprnd_q <= '0;
`ifdef FETCH_CALL_STACK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
            phase_q <= phase_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
`ifdef FETCH_CALL_STACK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign PC    = pc_q;
    assign phase = phase_q;
    assign instr = instr_q;
    assign oprnd = oprnd_q;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 12, program-counter width.
REQ-002 SHALL have parameter INSTR_W, default 4, opcode field width.
REQ-003 SHALL have parameter OPRND_W, default 4, operand field width; program_byte width = INSTR_W+OPRND_W.
REQ-004 SHALL have parameter STACK_DEPTH, default 4, call-stack entries (>=2).
REQ-005 SHALL have a single clock; reset is synchronous and active-high; ports named clock and reset.
REQ-006 SHALL have ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- enable  input  1  advance sequencer when high
- program_byte  input  INSTR_W+OPRND_W  ROM data at address PC
- load_pc  input  1  jump request, sampled in execute phase
- call  input  1  call request, sampled in execute phase
- ret  input  1  return request, sampled in execute phase
- load_addr  input  PC_W  jump/call target
- PC  output  PC_W  program counter / ROM address
- phase  output  1  0 = fetch, 1 = execute
- instr  output  INSTR_W  latched opcode (upper field)
- oprnd  output  OPRND_W  latched operand (lower field)
- stack_err  output  1  sticky overflow/underflow flag
- stack_level  output  clog2(STACK_DEPTH+1)  occupied stack entries

Function
REQ-007 SHALL change no state on an edge with enable=0 (reset excepted).
REQ-008 SHALL, on an enabled edge with phase=0: load {instr,oprnd} from program_byte (instr = upper INSTR_W bits), set PC to PC+1 modulo 2^PC_W, set phase=1.
REQ-009 SHALL, on an enabled edge with phase=1, set phase=0 and update PC by priority ret > call > load_pc > hold.
REQ-010 SHALL ignore load_pc, call and ret while phase=0.
REQ-011 SHALL, on load_pc, set PC=load_addr.
REQ-012 SHALL, on call with stack not full, push current PC (the return address) and set PC=load_addr.
REQ-013 SHALL, on call with stack full, leave PC and stack unchanged and set stack_err.
REQ-014 SHALL, on ret with stack not empty, set PC=top entry and pop.
REQ-015 SHALL, on ret with stack empty, leave PC unchanged and set stack_err.
REQ-016 SHALL keep stack_err high until reset once set.
REQ-017 SHALL hold instr/oprnd stable throughout execute phase; PC wraps from all-ones to 0 without flagging.

Reset
REQ-018 SHALL, on reset=1 at a clock edge, regardless of enable or phase: PC=0, phase=0, instr=0, oprnd=0, stack_level=0, stack_err=0.
REQ-019 SHALL discard any pending call/ret/load_pc coincident with reset.

Configuration
REQ-020 SHALL compile the call stack only when macro FETCH_CALL_STACK_EN is defined.
REQ-021 SHALL, without FETCH_CALL_STACK_EN, ignore call and ret (load_pc still honoured), tie stack_err and stack_level to 0, and instantiate no stack storage.

Structure
REQ-022 SHALL take default widths, STACK_DEPTH default and phase constants PH_FETCH=0/PH_EXEC=1 from shared package fetch_pkg.
REQ-023 SHALL implement the LIFO as sub-module call_stack (push, pop, data in/out, full, empty, level), instantiated only under FETCH_CALL_STACK_EN.

Verification
REQ-024 SHALL cover: reset, enable=1, program_byte=8'h5A -> after edge 1 phase=1, PC=1, instr=4'h5, oprnd=4'hA; after edge 2 phase=0, PC=1.
REQ-025 SHALL cover: phase=1, PC=12'h010, load_pc=1, load_addr=12'h200 -> PC=12'h200, stack_level unchanged.
REQ-026 SHALL cover (macro on): call to 12'h300 at PC=12'h011, then ret in a later execute phase -> PC=12'h300 then 12'h011, stack_level 1 then 0.
REQ-027 SHALL cover (macro on): 5 nested calls with STACK_DEPTH=4 -> fifth call leaves PC unchanged, stack_err=1, stack_level=4; ret on empty stack also sets stack_err.
REQ-028 SHALL cover: PC=12'hFFF fetch -> PC=12'h000; enable=0 for 3 edges -> all outputs frozen; reset asserted in execute phase with call=1 -> PC=0, phase=0, stack_level=0.
REQ-029 SHALL cover (macro off): call=1, ret=1 in execute phase -> PC holds, stack_err=0; load_pc still jumps.
